// File: rtl/oops_structs.sv
// -----------------------------------------------------------------------------
// oops_structs
// Shared types for the common data bus (CDB) and its producers.
//   cdb_result_t      : one functional-unit result (32-bit data + ROB destination)
//   cdb_lane_t        : one CDB lane as seen by consumers (valid, rob_dest, data)
//   common_data_bus_t : NUM_CDB_INPUTS lanes plus the one-cycle flush marker fls
// -----------------------------------------------------------------------------
package oops_structs;

   localparam int NUM_CDB_INPUTS = 2;
   localparam int ROB_IDX_LEN    = 6;
   localparam int CDB_DATA_W     = 32;

   typedef struct packed {
      logic [CDB_DATA_W-1:0]  data;
      logic [ROB_IDX_LEN-1:0] rob_dest;
   } cdb_result_t;

   typedef struct packed {
      logic                   valid;
      logic [ROB_IDX_LEN-1:0] rob_dest;
      logic [CDB_DATA_W-1:0]  data;
   } cdb_lane_t;

   typedef struct packed {
      cdb_lane_t [NUM_CDB_INPUTS-1:0] lanes;
      logic                           fls;
   } common_data_bus_t;

   function automatic cdb_lane_t to_lane(input cdb_result_t r);
      cdb_lane_t l;
      l.valid    = 1'b1;
      l.rob_dest = r.rob_dest;
      l.data     = r.data;
      return l;
   endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// -----------------------------------------------------------------------------
// cdb_result_fifo
// Per-producer result buffer in front of the CDB arbiter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write one result (caller guarantees not_full was 1)
//   pop        : drop the head entry (caller guarantees not_empty)
//   clear      : discard all entries (flush); dominates push/pop
//   head       : current head entry, valid while not_empty
//   not_empty  : at least one entry held
//   not_full   : registered; 1 iff fewer than DEPTH entries at cycle start,
//                held 0 during reset
// -----------------------------------------------------------------------------
module cdb_result_fifo
   import oops_structs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        clear,
   input  cdb_result_t din,
   output cdb_result_t head,
   output logic        not_empty,
   output logic        not_full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   cdb_result_t     mem [DEPTH];
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_nxt;

   always_comb begin
      count_nxt = count_q;
      if (push && !pop)
         count_nxt = count_q + CNT_ONE;
      else if (!push && pop)
         count_nxt = count_q - CNT_ONE;
   end

   // Storage needs no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         not_full <= 1'b0;
      end else if (clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         not_full <= 1'b1;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q  <= count_nxt;
         // Reflects occupancy at the start of the next cycle, so a pop in
         // the current cycle cannot raise the ready seen this cycle.
         not_full <= (count_nxt < DEPTH_C);
      end
   end

   assign head      = mem[rd_ptr_q];
   assign not_empty = (count_q != '0);

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Buffers results from NUM_PRODUCERS functional units and grants up to
// NUM_CDB_INPUTS of them per cycle onto the registered common data bus.
// Build option: CDB_ARB_ROUND_ROBIN_EN
//   defined   : round-robin search starting at a pointer that moves past the
//               last granted producer after any cycle with a grant
//   undefined : fixed priority, lowest producer index first (no pointer)
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : mispredict flush; clears buffers, blanks lanes, fls=1 next cycle
//   vld_i / rdy_i     : per-producer handshake, transfer when both are 1
//   data_i            : per-producer result
//   common_data_bus_o : registered lanes (grant order) plus fls
// -----------------------------------------------------------------------------
module cdb_arbiter
   import oops_structs::*;
#(
   parameter int NUM_PRODUCERS = 4,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush_i,
   input  logic [NUM_PRODUCERS-1:0]             vld_i,
   output logic [NUM_PRODUCERS-1:0]             rdy_i,
   input  cdb_result_t [NUM_PRODUCERS-1:0]      data_i,
   output common_data_bus_t                     common_data_bus_o
);

   localparam int PW = (NUM_PRODUCERS > 1) ? $clog2(NUM_PRODUCERS) : 1;
   localparam int LW = (NUM_CDB_INPUTS > 1) ? $clog2(NUM_CDB_INPUTS) : 1;

   logic [NUM_PRODUCERS-1:0]        push;
   logic [NUM_PRODUCERS-1:0]        gnt;
   logic [NUM_PRODUCERS-1:0]        not_empty;
   logic [NUM_PRODUCERS-1:0]        not_full;
   cdb_result_t                     head [NUM_PRODUCERS];
   cdb_lane_t [NUM_CDB_INPUTS-1:0]  lanes_nxt;
   common_data_bus_t                bus_q;

`ifdef CDB_ARB_ROUND_ROBIN_EN
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_nxt;
`endif

   assign rdy_i = not_full;
   // A result offered during a flush is acknowledged but never stored.
   assign push  = vld_i & rdy_i & {NUM_PRODUCERS{~flush_i}};

   for (genvar g = 0; g < NUM_PRODUCERS; g++) begin : g_fifo
      cdb_result_fifo #(
         .DEPTH     (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[g]),
         .pop       (gnt[g]),
         .clear     (flush_i),
         .din       (data_i[g]),
         .head      (head[g]),
         .not_empty (not_empty[g]),
         .not_full  (not_full[g])
      );
   end

   // Walk the producers once in priority order, handing each non-empty head
   // the next free lane. One visit per producer means one grant per producer,
   // and equal rob_dest values are never merged. No grants during a flush.
   always_comb begin : grant_search
      int n;
      int idx;
      gnt       = '0;
      lanes_nxt = '0;
      n         = 0;
      idx       = 0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
      ptr_nxt   = ptr_q;
`endif
      if (!flush_i) begin
         for (int i = 0; i < NUM_PRODUCERS; i++) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
            idx = int'(ptr_q) + i;
            if (idx >= NUM_PRODUCERS)
               idx = idx - NUM_PRODUCERS;
`else
            idx = i;
`endif
            if (not_empty[PW'(idx)] && (n < NUM_CDB_INPUTS)) begin
               gnt[PW'(idx)]    = 1'b1;
               lanes_nxt[LW'(n)] = to_lane(head[PW'(idx)]);
               n                = n + 1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
               ptr_nxt = (idx == NUM_PRODUCERS - 1) ? '0 : PW'(idx + 1);
`endif
            end
         end
      end
   end

`ifdef CDB_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst)
         ptr_q <= '0;
      else
         ptr_q <= ptr_nxt;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_q <= '0;
      end else begin
         bus_q.lanes <= lanes_nxt;
         bus_q.fls   <= flush_i;
      end
   end

   assign common_data_bus_o = bus_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
   import oops_structs::*;

   localparam int NP = 4;

   logic                       clk;
   logic                       rst;
   logic                       flush_i;
   logic [NP-1:0]              vld_i;
   logic [NP-1:0]              rdy_i;
   cdb_result_t [NP-1:0]       data_i;
   common_data_bus_t           common_data_bus_o;

   cdb_arbiter #(
      .NUM_PRODUCERS     (NP),
      .FIFO_DEPTH        (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .flush_i           (flush_i),
      .vld_i             (vld_i),
      .rdy_i             (rdy_i),
      .data_i            (data_i),
      .common_data_bus_o (common_data_bus_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       f;
      logic [3:0] v;
      logic [3:0] er;
      int         l0;
      int         l1;
      logic       ef;
   } vec_t;

   localparam int N = -1;

   vec_t        tbl[$];
   cdb_result_t exp_q [NP][$];
   int          seq [NP];
   int          checks;
   int          failures;
   int          cyc_n;
   logic        ovr_en;
   cdb_result_t ovr_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic [3:0] v, input logic [3:0] er,
                      input int l0, input int l1, input logic ef);
      vec_t e;
      e.r = r; e.f = f; e.v = v; e.er = er; e.l0 = l0; e.l1 = l1; e.ef = ef;
      tbl.push_back(e);
   endtask

   // One cycle: drive inputs, compare outputs produced by the previous edge,
   // update the scoreboard for what the coming edge accepts, then clock.
   task automatic cyc(input logic r, input logic f, input logic [3:0] v, input logic [3:0] er,
                      input int l0, input int l1, input logic ef);
      int          src;
      cdb_result_t e;
      rst     = r;
      flush_i = f;
      vld_i   = v;
      for (int p = 0; p < NP; p++) begin
         data_i[p].data     = {8'(p), 24'(seq[p])};
         data_i[p].rob_dest = ROB_IDX_LEN'(seq[p]);
      end
      if (ovr_en) data_i[0] = ovr_val;

      chk("rdy", 64'(rdy_i), 64'(er));
      chk("fls", 64'(common_data_bus_o.fls), 64'(ef));
      for (int j = 0; j < NUM_CDB_INPUTS; j++) begin
         src = (j == 0) ? l0 : l1;
         chk($sformatf("lane%0d_valid", j), 64'(common_data_bus_o.lanes[j].valid), 64'(src >= 0));
         if (src >= 0 && common_data_bus_o.lanes[j].valid) begin
            if (exp_q[src].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL lane%0d_src cycle %0d: got data %0h expected nothing queued for p%0d",
                        j, cyc_n, common_data_bus_o.lanes[j].data, src);
            end else begin
               e = exp_q[src].pop_front();
               chk($sformatf("lane%0d_data", j), 64'(common_data_bus_o.lanes[j].data), 64'(e.data));
               chk($sformatf("lane%0d_dest", j), 64'(common_data_bus_o.lanes[j].rob_dest), 64'(e.rob_dest));
            end
         end
      end

      for (int p = 0; p < NP; p++) begin
         if (v[p] && er[p] && !f && !r) begin
            exp_q[p].push_back(data_i[p]);
            seq[p]++;
         end
      end
      if (f || r)
         for (int p = 0; p < NP; p++) exp_q[p].delete();

      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc_n    = 0;
      ovr_en   = 1'b0;
      ovr_val  = '0;
      for (int p = 0; p < NP; p++) seq[p] = 0;
      rst      = 1'b1;
      flush_i  = 1'b0;
      vld_i    = '0;
      data_i   = '0;
      repeat (2) @(posedge clk);
      #1;

      // reset state and first cycle after release
      add(1, 0, 4'b0000, 4'b0000, N, N, 0);
      add(0, 0, 4'b0000, 4'b0000, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      // all four push at once, two lanes: p0,p1 at t+2, p2,p3 at t+3
      add(0, 0, 4'b1111, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, 0, 1, 0);
      add(0, 0, 4'b0000, 4'b1111, 2, 3, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      // flush with three buffered and a fourth offered on the flush edge
      add(0, 0, 4'b0111, 4'b1111, N, N, 0);
      add(0, 1, 4'b1000, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 1);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      // back-to-back flushes give back-to-back fls
      add(0, 1, 4'b0000, 4'b1111, N, N, 0);
      add(0, 1, 4'b0000, 4'b1111, N, N, 1);
      add(0, 0, 4'b0000, 4'b1111, N, N, 1);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      // fill FIFOs, then reset (with a flush that reset must override)
      add(0, 0, 4'b1111, 4'b1111, N, N, 0);
      add(0, 0, 4'b1111, 4'b1111, N, N, 0);
`ifdef CDB_ARB_ROUND_ROBIN_EN
      add(0, 0, 4'b1111, 4'b0011, 0, 1, 0);
      add(1, 1, 4'b1111, 4'b1100, 2, 3, 0);
`else
      add(0, 0, 4'b1111, 4'b0011, 0, 1, 0);
      add(1, 1, 4'b1111, 4'b0011, 0, 1, 0);
`endif
      add(0, 0, 4'b0000, 4'b0000, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
`ifdef CDB_ARB_ROUND_ROBIN_EN
      // rotation: p3 is served ahead of p0 once the pointer passes p1
      add(0, 0, 4'b1011, 4'b1111, N, N, 0);
      add(0, 0, 4'b1011, 4'b1111, N, N, 0);
      add(0, 0, 4'b0000, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b0000, 4'b1111, 3, 0, 0);
      add(0, 0, 4'b0000, 4'b1111, 1, 3, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
`else
      // p0,p1 hold both lanes: p3 starves, fills after two accepts, recovers
      add(0, 0, 4'b1011, 4'b1111, N, N, 0);
      add(0, 0, 4'b1011, 4'b1111, N, N, 0);
      add(0, 0, 4'b1011, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b1011, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b1011, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b1000, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b1000, 4'b0111, 0, 1, 0);
      add(0, 0, 4'b1000, 4'b1111, 3, N, 0);
      add(0, 0, 4'b0000, 4'b1111, 3, N, 0);
      add(0, 0, 4'b0000, 4'b1111, 3, N, 0);
      add(0, 0, 4'b0000, 4'b1111, N, N, 0);
`endif

      for (int k = 0; k < tbl.size(); k++)
         cyc(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].er, tbl[k].l0, tbl[k].l1, tbl[k].ef);

      // single known result: lane0 two cycles after acceptance, not earlier
      cyc(1, 0, 4'b0000, 4'b1111, N, N, 0);
      cyc(0, 0, 4'b0000, 4'b0000, N, N, 0);
      ovr_en           = 1'b1;
      ovr_val.data     = 32'hDEAD_BEEF;
      ovr_val.rob_dest = ROB_IDX_LEN'(5);
      cyc(0, 0, 4'b0001, 4'b1111, N, N, 0);
      ovr_en           = 1'b0;
      cyc(0, 0, 4'b0000, 4'b1111, N, N, 0);
      chk("single_valid", 64'(common_data_bus_o.lanes[0].valid), 64'(1));
      chk("single_data",  64'(common_data_bus_o.lanes[0].data), 64'(32'hDEAD_BEEF));
      chk("single_dest",  64'(common_data_bus_o.lanes[0].rob_dest), 64'(5));
      chk("single_lane1", 64'(common_data_bus_o.lanes[1].valid), 64'(0));
      cyc(0, 0, 4'b0000, 4'b1111, 0, N, 0);
      cyc(0, 0, 4'b0000, 4'b1111, N, N, 0);

      for (int p = 0; p < NP; p++)
         chk($sformatf("drained_p%0d", p), 64'(exp_q[p].size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_PRODUCERS, default 4: number of functional-unit result sources.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: result entries buffered per producer, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: ROB mispredict flush request.
REQ-006 SHALL have port vld_i, input, NUM_PRODUCERS bits: producer result valid.
REQ-007 SHALL have port rdy_i, output, NUM_PRODUCERS bits: arbiter can accept that producer's result.
REQ-008 SHALL have port data_i, input, NUM_PRODUCERS x cdb_result_t: result data (32-bit value, ROB_dest of ROB_IDX_LEN bits).
REQ-009 SHALL have port common_data_bus_o, output, common_data_bus_t: NUM_CDB_INPUTS lanes (valid, ROB_dest, data) plus fls.

Function
REQ-010 SHALL transfer a result from producer p on any rising edge where vld_i[p] and rdy_i[p] are both 1.
REQ-011 SHALL drive rdy_i[p] from a register: 1 iff producer p's FIFO held fewer than FIFO_DEPTH entries at the start of the cycle. A same-cycle pop SHALL NOT raise rdy_i.
REQ-012 SHALL, each cycle, grant up to NUM_CDB_INPUTS producers whose FIFO is non-empty. Each producer gets at most one grant per cycle. Only the FIFO head is eligible.
REQ-013 SHALL assign granted results to lanes 0, 1, ... in grant order. Ungranted lanes SHALL have valid 0.
REQ-014 SHALL register lane outputs: a result accepted at edge t is granted in cycle t+1 at the earliest and is visible on the bus in cycle t+2.
REQ-015 SHALL pop a FIFO head on the edge at which it is granted. Each accepted result SHALL appear on the bus exactly once, in per-producer acceptance order.
REQ-016 SHALL, when flush_i is 1 at an edge, perform all of the following on that edge: clear all FIFOs, drop any result transferred on that edge, load all lane valid bits as 0, and set common_data_bus_o.fls to 1 for the following cycle.
REQ-017 SHALL drive common_data_bus_o.fls for exactly one cycle per flush_i cycle, so consecutive flush cycles produce consecutive fls cycles.
REQ-018 SHALL keep rdy_i per REQ-011 through a flush. Writers acknowledged during a flush are discarded, not stalled.
REQ-019 SHALL NOT combine results that carry the same ROB_dest: each occupies its own lane in its own grant.

Reset
REQ-020 SHALL, while rst is 1, empty all FIFOs, and set rdy_i to 0, all lane valid to 0, fls to 0, and the round-robin pointer to 0.
REQ-021 SHALL drive rdy_i to all ones on the first cycle after rst deasserts.
REQ-022 SHALL let rst override flush_i and any in-progress transfer.

Configuration
REQ-023 SHALL use macro CDB_ARB_ROUND_ROBIN_EN.
- Defined: grant search starts at pointer ptr. After a cycle with at least one grant, ptr moves to (last granted index + 1) mod NUM_PRODUCERS. Otherwise ptr holds.
- Undefined: fixed priority, lowest producer index first; no pointer register.

Structure
REQ-024 SHALL place cdb_result_t in package oops_structs, beside common_data_bus_t; NUM_CDB_INPUTS and ROB_IDX_LEN remain package constants.
REQ-025 SHALL implement per-producer buffering as sub-module cdb_result_fifo (push, pop, clear, registered not-full flag), instantiated NUM_PRODUCERS times.

Verification
REQ-026 SHALL cover: reset, then single push p0 {ROB_dest 5, data 0xDEADBEEF} -> lane0 valid with those values exactly two cycles later, all other lanes valid 0.
REQ-027 SHALL cover: all 4 producers push in the same cycle with NUM_CDB_INPUTS=2, round robin -> p0,p1 on the bus in cycle t+2, p2,p3 in t+3, nothing lost.
REQ-028 SHALL cover: producer 1 pushes continuously with the bus stalled by higher-priority traffic -> rdy_i[1] drops after 2 accepts, rises the cycle after a pop, and ordering is preserved.
REQ-029 SHALL cover: flush_i asserted with 3 results buffered and a push in the same cycle -> next cycle fls=1, all lanes valid 0, and none of the 4 results ever appears.
REQ-030 SHALL cover: rst asserted mid-stream with full FIFOs -> the next cycle has rdy_i 0, no lanes valid, fls 0; the cycle after has rdy_i all ones.
REQ-031 SHALL cover: fixed priority build (macro undefined), p0 and p3 continuously valid with 1 lane -> only p0 granted, demonstrating intentional starvation.
